// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file definitions for the writeback arbiter.
// Optional feature macro used by this slice: REGARB_BYPASS_EN.
package regfile_pkg;

    localparam int REG_ADDR_W = 4;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 16;

    // One writeback request as seen by the register file.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_req_t;

    // Round-robin successor of index idx among n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus between the writeback requesters and the register-file write port.
// Handshake: a requester raises req_valid[i] with stable req_addr/req_data and
// keeps it raised; the write is accepted in the cycle where req_valid[i] and
// req_ready[i] are both 1, and appears on writeReg/writeData/regWrite one cycle later.
// With REGARB_BYPASS_EN defined the bus also carries the read-port forwarding signals.
interface regfile_write_arbiter_if #(
    parameter int NREQ   = 2,
    parameter int ADDR_W = regfile_pkg::REG_ADDR_W,
    parameter int DATA_W = regfile_pkg::REG_DATA_W
) ();
    import regfile_pkg::*;

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic                   hold;
    logic [ADDR_W-1:0]      writeReg;
    logic [DATA_W-1:0]      writeData;
    logic                   regWrite;
`ifdef REGARB_BYPASS_EN
    logic [ADDR_W-1:0]      rd_addr1;
    logic [ADDR_W-1:0]      rd_addr2;
    logic                   fwd_hit1;
    logic                   fwd_hit2;
    logic [DATA_W-1:0]      fwd_data;

    modport master (
        output req_valid, req_addr, req_data, hold, rd_addr1, rd_addr2,
        input  req_ready, writeReg, writeData, regWrite, fwd_hit1, fwd_hit2, fwd_data
    );
    modport slave (
        input  req_valid, req_addr, req_data, hold, rd_addr1, rd_addr2,
        output req_ready, writeReg, writeData, regWrite, fwd_hit1, fwd_hit2, fwd_data
    );
`else
    modport master (
        output req_valid, req_addr, req_data, hold,
        input  req_ready, writeReg, writeData, regWrite
    );
    modport slave (
        input  req_valid, req_addr, req_data, hold,
        output req_ready, writeReg, writeData, regWrite
    );
`endif

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first valid index at or after i_ptr,
// wrapping to the lowest valid index; nothing is granted while i_hold is set.
module rr_arbiter
    import regfile_pkg::*;
#(
    parameter  int NREQ  = 2,
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_valid,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic             i_hold,
    output logic [NREQ-1:0]  o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic             w_hi_found;
    logic             w_lo_found;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_lo_idx;

    // Split search: lowest valid index >= i_ptr wins, else lowest valid overall (wrap).
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (i_valid[i]) begin
                if (!w_hi_found && (IDX_W'(i) >= i_ptr)) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IDX_W'(i);
                end
                if (!w_lo_found) begin
                    w_lo_found = 1'b1;
                    w_lo_idx   = IDX_W'(i);
                end
            end
        end
    end

    // Final grant, one-hot on the selected index, suppressed by hold.
    always_comb begin
        o_any   = !i_hold && (w_hi_found || w_lo_found);
        o_idx   = w_hi_found ? w_hi_idx : w_lo_idx;
        o_grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            o_grant[i] = o_any && (o_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Writeback arbiter for the register file's single write port.
// NREQ requesters compete round-robin; the winner is registered and driven to
// the register file one cycle after acceptance.
// Optional feature macro: REGARB_BYPASS_EN adds same-cycle read forwarding
// from the output register (rd_addr1/2 -> fwd_hit1/2, fwd_data).
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter  int NREQ   = 2,
    parameter  int ADDR_W = REG_ADDR_W,
    parameter  int DATA_W = REG_DATA_W,
    localparam int IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus,
    output logic [IDX_W-1:0]        dbg_rr_ptr
);

    logic [IDX_W-1:0]  r_rr_ptr;
    logic [ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0] r_write_data;
    logic              r_reg_write;

    logic [NREQ-1:0]   w_grant;
    logic [IDX_W-1:0]  w_grant_idx;
    logic              w_grant_any;
    logic [NREQ-1:0]   w_ready;
    logic              w_accept;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic [IDX_W-1:0]  w_ptr_next;

    rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
        .i_valid (bus.req_valid),
        .i_ptr   (r_rr_ptr),
        .i_hold  (bus.hold),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_any   (w_grant_any)
    );

    // Ready is forced low while reset is held so nothing is accepted then.
    assign w_ready       = reset ? w_grant : '0;
    assign bus.req_ready = w_ready;
    assign w_accept      = |(bus.req_valid & w_ready);
    assign w_ptr_next    = IDX_W'(rr_next(int'(w_grant_idx), NREQ));

    // Pick the granted requester's address and data (grant is one-hot).
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Output register and round-robin pointer; a pending write is dropped on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr     <= '0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_reg_write  <= 1'b0;
        end else begin
            r_reg_write <= w_accept;
            if (w_accept) begin
                r_write_reg  <= w_sel_addr;
                r_write_data <= w_sel_data;
                r_rr_ptr     <= w_ptr_next;
            end
        end
    end

    assign bus.writeReg  = r_write_reg;
    assign bus.writeData = r_write_data;
    assign bus.regWrite  = r_reg_write;
    assign dbg_rr_ptr    = r_rr_ptr;

`ifdef REGARB_BYPASS_EN
    // Forward the write being committed this cycle to matching readers.
    assign bus.fwd_hit1 = r_reg_write && (r_write_reg == bus.rd_addr1);
    assign bus.fwd_hit2 = r_reg_write && (r_write_reg == bus.rd_addr2);
    assign bus.fwd_data = r_write_data;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter (NREQ=2, 16 x 32-bit registers).
// Define REGARB_BYPASS_EN to also exercise the forwarding ports.
module tb_regfile_write_arbiter;

    localparam int NREQ   = 2;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    // ---------------- clock / reset ----------------
    logic       clk;
    logic       reset;
    logic [0:0] dbg_ptr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    regfile_write_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .dbg_rr_ptr (dbg_ptr)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] regs [16];
    logic prev_acc = 1'b0;

    typedef struct {
        logic [1:0]  valid;
        logic        hold;
        logic [3:0]  a0;
        logic [31:0] d0;
        logic [3:0]  a1;
        logic [31:0] d1;
        logic [1:0]  exp_ready;
        logic        exp_ptr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic add_vec(input logic [1:0] v, input logic h,
                           input logic [3:0] a0, input logic [31:0] d0,
                           input logic [3:0] a1, input logic [31:0] d1,
                           input logic [1:0] er, input logic ep);
        vec_t t;
        t.valid = v; t.hold = h; t.a0 = a0; t.d0 = d0; t.a1 = a1; t.d1 = d1;
        t.exp_ready = er; t.exp_ptr = ep;
        vecs.push_back(t);
    endtask

    // Compare the registered output against the scoreboard after an edge.
    task automatic check_output(input string name, input logic expect_write);
        logic [ADDR_W+DATA_W-1:0] e;
        check({name, " regWrite"}, 64'(bus.regWrite), 64'(expect_write));
        if (bus.regWrite) begin
            if (exp_q.size() == 0) begin
                check({name, " unexpected write"}, 64'(1), 64'(0));
            end else begin
                e = exp_q.pop_front();
                check({name, " writeReg"}, 64'(bus.writeReg), 64'(e[DATA_W +: ADDR_W]));
                check({name, " writeData"}, 64'(bus.writeData), 64'(e[DATA_W-1:0]));
            end
            regs[bus.writeReg] = bus.writeData;
        end
    endtask

    // Drive one vector for one cycle and compare ready, output, pointer.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        bus.req_valid = v.valid;
        bus.hold      = v.hold;
        bus.req_addr  = {v.a1, v.a0};
        bus.req_data  = {v.d1, v.d0};
        #1;
        check({name, " ready"}, 64'(bus.req_ready), 64'(v.exp_ready));
        check({name, " mid regWrite"}, 64'(bus.regWrite), 64'(prev_acc));
        if (v.exp_ready[0])      exp_q.push_back({v.a0, v.d0});
        else if (v.exp_ready[1]) exp_q.push_back({v.a1, v.d1});
        @(posedge clk);
        #1;
        check_output(name, v.exp_ready != 2'b00);
        check({name, " rr_ptr"}, 64'(dbg_ptr), 64'(v.exp_ptr));
        prev_acc = (v.exp_ready != 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = '0;
        bus.req_valid = 2'b11;
        bus.hold      = 1'b0;
        bus.req_addr  = {4'd1, 4'd2};
        bus.req_data  = {32'h1, 32'h2};
`ifdef REGARB_BYPASS_EN
        bus.rd_addr1  = 4'd0;
        bus.rd_addr2  = 4'd0;
`endif
        reset = 1'b0;

        // Reset state, with requesters already asserting valid.
        repeat (2) @(posedge clk);
        #1;
        check("reset ready", 64'(bus.req_ready), 64'(0));
        check("reset regWrite", 64'(bus.regWrite), 64'(0));
        check("reset writeReg", 64'(bus.writeReg), 64'(0));
        check("reset writeData", 64'(bus.writeData), 64'(0));
        check("reset rr_ptr", 64'(dbg_ptr), 64'(0));
`ifdef REGARB_BYPASS_EN
        check("reset fwd_hit1", 64'(bus.fwd_hit1), 64'(0));
        check("reset fwd_hit2", 64'(bus.fwd_hit2), 64'(0));
        check("reset fwd_data", 64'(bus.fwd_data), 64'(0));
`endif
        @(negedge clk);
        bus.req_valid = 2'b00;
        reset = 1'b1;

        // Reset mid-write: accepted write must be dropped.
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.req_addr  = {4'd0, 4'd5};
        bus.req_data  = {32'h0, 32'hDEAD_BEEF};
        #1;
        check("rstmid ready", 64'(bus.req_ready), 64'(2'b01));
        #2;
        reset = 1'b0;
        #1;
        check("rstmid ready in reset", 64'(bus.req_ready), 64'(0));
        @(posedge clk);
        #1;
        check("rstmid regWrite", 64'(bus.regWrite), 64'(0));
        check("rstmid writeReg", 64'(bus.writeReg), 64'(0));
        check("rstmid rr_ptr", 64'(dbg_ptr), 64'(0));
        @(negedge clk);
        bus.req_valid = 2'b00;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid after regWrite", 64'(bus.regWrite), 64'(0));
        check("rstmid reg5", 64'(regs[5]), 64'(0));
        prev_acc = 1'b0;

        // Vector table, starting from rr_ptr = 0.
        // single requester
        add_vec(2'b01, 0, 4'd3, 32'h1234_5678, 4'd0, 32'h0,          2'b01, 1'b1);
        add_vec(2'b00, 0, 4'd0, 32'h0,         4'd0, 32'h0,          2'b00, 1'b1);
        // bring pointer back to 0
        add_vec(2'b10, 0, 4'd0, 32'h0,         4'd2, 32'h2222_0000,  2'b10, 1'b0);
        // contention: 0,1,0,1
        add_vec(2'b11, 0, 4'd1, 32'hA000_0001, 4'd2, 32'hB000_0001,  2'b01, 1'b1);
        add_vec(2'b11, 0, 4'd1, 32'hA000_0002, 4'd2, 32'hB000_0001,  2'b10, 1'b0);
        add_vec(2'b11, 0, 4'd1, 32'hA000_0002, 4'd2, 32'hB000_0002,  2'b01, 1'b1);
        add_vec(2'b11, 0, 4'd1, 32'hA000_0003, 4'd2, 32'hB000_0002,  2'b10, 1'b0);
        add_vec(2'b01, 0, 4'd1, 32'hA000_0003, 4'd0, 32'h0,          2'b01, 1'b1);
        add_vec(2'b10, 0, 4'd0, 32'h0,         4'd6, 32'h0000_0066,  2'b10, 1'b0);
        add_vec(2'b00, 0, 4'd0, 32'h0,         4'd0, 32'h0,          2'b00, 1'b0);
        // same address conflict
        add_vec(2'b11, 0, 4'd7, 32'hA,         4'd7, 32'hB,          2'b01, 1'b1);
        add_vec(2'b10, 0, 4'd0, 32'h0,         4'd7, 32'hB,          2'b10, 1'b0);
        add_vec(2'b00, 0, 4'd0, 32'h0,         4'd0, 32'h0,          2'b00, 1'b0);
        // hold for three cycles, then grant on release
        add_vec(2'b10, 1, 4'd0, 32'h0,         4'd8, 32'h88,         2'b00, 1'b0);
        add_vec(2'b10, 1, 4'd0, 32'h0,         4'd8, 32'h88,         2'b00, 1'b0);
        add_vec(2'b10, 1, 4'd0, 32'h0,         4'd8, 32'h88,         2'b00, 1'b0);
        add_vec(2'b10, 0, 4'd0, 32'h0,         4'd8, 32'h88,         2'b10, 1'b0);
        add_vec(2'b00, 0, 4'd0, 32'h0,         4'd0, 32'h0,          2'b00, 1'b0);
        // registered write still issues while hold is raised
        add_vec(2'b01, 0, 4'd10, 32'hAAAA,     4'd0, 32'h0,          2'b01, 1'b1);
        add_vec(2'b10, 1, 4'd0, 32'h0,         4'd11, 32'hBBBB,      2'b00, 1'b1);
        add_vec(2'b10, 0, 4'd0, 32'h0,         4'd11, 32'hBBBB,      2'b10, 1'b0);
        add_vec(2'b00, 0, 4'd0, 32'h0,         4'd0, 32'h0,          2'b00, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        check("reg3 value", 64'(regs[3]), 64'(32'h1234_5678));
        check("reg7 last wins", 64'(regs[7]), 64'(32'hB));
        check("reg8 after hold", 64'(regs[8]), 64'(32'h88));
        check("reg11 after hold", 64'(regs[11]), 64'(32'hBBBB));

`ifdef REGARB_BYPASS_EN
        // Forwarding during the commit cycle.
        @(negedge clk);
        bus.req_valid = 2'b01;
        bus.hold      = 1'b0;
        bus.req_addr  = {4'd0, 4'd9};
        bus.req_data  = {32'h0, 32'h55};
        exp_q.push_back({4'd9, 32'h55});
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        bus.rd_addr1  = 4'd9;
        bus.rd_addr2  = 4'd4;
        #1;
        check("bypass fwd_hit1", 64'(bus.fwd_hit1), 64'(1));
        check("bypass fwd_hit2", 64'(bus.fwd_hit2), 64'(0));
        check("bypass fwd_data", 64'(bus.fwd_data), 64'(32'h55));
        check_output("bypass", 1'b1);
        @(posedge clk);
        #1;
        check("bypass idle fwd_hit1", 64'(bus.fwd_hit1), 64'(0));
`endif

        check("scoreboard empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
